// File: rtl/uart_tx_ctrl_if.sv
// Byte-in / serial-out bundle between a parity-generating source and the UART transmitter.
// The master side is the source and the slave side is the transmitter; clk and rst stay outside the bundle.
interface uart_tx_ctrl_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  data_valid;
  logic [DATA_WIDTH-1:0] P_data;
  logic                  PAR_EN;
  logic                  P_bit;
  logic                  TX_OUT;
  logic                  busy;
  logic                  frame_done;

  modport master (
    output data_valid, P_data, PAR_EN, P_bit,
    input  TX_OUT, busy, frame_done
  );

  modport slave (
    input  data_valid, P_data, PAR_EN, P_bit,
    output TX_OUT, busy, frame_done
  );
endinterface

// File: rtl/uart_tx_ctrl.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB first, optional parity, stop bit; one bit per clk.
// TX_OUT shows the start bit one cycle after acceptance; data_valid is ignored while busy, with no queueing.
module uart_tx_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input logic           clk,
  input logic           rst,
  uart_tx_ctrl_if.slave bus
);
  localparam int CW = $clog2(DATA_WIDTH);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic                  par_en_q, par_en_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shreg_q  <= '0;
      par_en_q <= 1'b0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shreg_q  <= shreg_d;
      par_en_q <= par_en_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Every output is computed one bit ahead so that TX_OUT, busy and frame_done come straight from flops.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shreg_d  = shreg_q;
    par_en_d = par_en_q;
    tx_d     = tx_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (bus.data_valid && !busy_q) begin
          shreg_d  = bus.P_data;
          par_en_d = bus.PAR_EN;
          cnt_d    = '0;
          tx_d     = 1'b0;
          busy_d   = 1'b1;
          state_d  = START;
        end
      end
      START: begin
        tx_d    = shreg_q[0];
        shreg_d = {1'b0, shreg_q[DATA_WIDTH-1:1]};
        state_d = DATA;
      end
      DATA: begin
        if (cnt_q == CW'(DATA_WIDTH - 1)) begin
          if (par_en_q) begin
            tx_d    = bus.P_bit;
            state_d = PARITY;
          end else begin
            tx_d    = 1'b1;
            done_d  = 1'b1;
            state_d = STOP;
          end
        end else begin
          tx_d    = shreg_q[0];
          shreg_d = {1'b0, shreg_q[DATA_WIDTH-1:1]};
          cnt_d   = cnt_q + CW'(1);
        end
      end
      PARITY: begin
        tx_d    = 1'b1;
        done_d  = 1'b1;
        state_d = STOP;
      end
      STOP: begin
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign bus.TX_OUT     = tx_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = done_q;
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl: table of frames with hand-written bit sequences plus corner-case sequences.
module tb_uart_tx_ctrl;
  logic clk;
  logic rst;

  uart_tx_ctrl_if #(.DATA_WIDTH(8)) bus ();

  uart_tx_ctrl #(.DATA_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // seq holds the transmitted bits in line order; the first bit is seq[len-1].
  typedef struct {
    logic [7:0]  data;
    logic        pe;
    logic        pb;
    int          len;
    logic [10:0] seq;
  } vec_t;

  vec_t vecs[6];
  vec_t v55;
  int   n_checks;
  int   n_errors;

  task automatic chk(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_idle(input string name);
    chk({name, " tx"}, bus.TX_OUT, 1'b1);
    chk({name, " busy"}, bus.busy, 1'b0);
    chk({name, " done"}, bus.frame_done, 1'b0);
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge of the idle cycle after the stop bit.
  task automatic send(input vec_t v, input int inject);
    bus.data_valid = 1'b1;
    bus.P_data     = v.data;
    bus.PAR_EN     = v.pe;
    bus.P_bit      = v.pb;
    @(negedge clk);
    for (int i = 0; i < v.len; i++) begin
      chk($sformatf("tx[%0d] of %h", i, v.data), bus.TX_OUT, v.seq[v.len-1-i]);
      chk($sformatf("busy[%0d] of %h", i, v.data), bus.busy, 1'b1);
      chk($sformatf("done[%0d] of %h", i, v.data), bus.frame_done, i == v.len - 1);
      bus.P_data = ~v.data;
      bus.PAR_EN = ~v.pe;
      if (!v.pe) bus.P_bit = ~bus.P_bit;
      if (i == inject) begin
        bus.data_valid = 1'b1;
        bus.P_data     = 8'hFF;
      end else begin
        bus.data_valid = 1'b0;
      end
      @(negedge clk);
    end
    chk_idle($sformatf("post-frame %h", v.data));
    bus.data_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    vecs[0] = '{8'hA5, 1'b1, 1'b0, 11, 11'b01010010101};
    vecs[1] = '{8'h0F, 1'b0, 1'b1, 10, 11'b00111100001};
    vecs[2] = '{8'h81, 1'b1, 1'b0, 11, 11'b01000000101};
    vecs[3] = '{8'h3C, 1'b1, 1'b1, 11, 11'b00011110011};
    vecs[4] = '{8'hFF, 1'b0, 1'b0, 10, 11'b00111111111};
    vecs[5] = '{8'h00, 1'b1, 1'b0, 11, 11'b00000000001};
    v55     = '{8'h55, 1'b1, 1'b0, 11, 11'b01010101001};

    rst            = 1'b0;
    bus.data_valid = 1'b0;
    bus.P_data     = 8'h00;
    bus.PAR_EN     = 1'b0;
    bus.P_bit      = 1'b0;
    @(negedge clk);
    chk_idle("in reset");
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk_idle($sformatf("idle %0d", i));
    end

    @(negedge clk);
    foreach (vecs[k]) send(vecs[k], -1);

    // A request in the fourth busy cycle must be dropped, not queued.
    send(vecs[3], 3);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_idle($sformatf("after drop %0d", i));
    end

    // data_valid held high: stop bit plus one idle cycle between frames.
    @(negedge clk);
    bus.data_valid = 1'b1;
    bus.P_data     = 8'h55;
    bus.PAR_EN     = 1'b1;
    bus.P_bit      = 1'b0;
    @(negedge clk);
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 12; i++) begin
        chk($sformatf("b2b tx f%0d b%0d", f, i), bus.TX_OUT, (i < 11) ? v55.seq[10-i] : 1'b1);
        chk($sformatf("b2b busy f%0d b%0d", f, i), bus.busy, i < 11);
        @(negedge clk);
      end
    end
    bus.data_valid = 1'b0;
    repeat (12) @(negedge clk);
    chk_idle("b2b drained");

    // Reset during data bit 3 of 0xA5 aborts the frame at once.
    bus.data_valid = 1'b1;
    bus.P_data     = 8'hA5;
    bus.PAR_EN     = 1'b1;
    bus.P_bit      = 1'b0;
    @(negedge clk);
    bus.data_valid = 1'b0;
    chk("abort start bit", bus.TX_OUT, 1'b0);
    repeat (4) @(negedge clk);
    chk("abort bit3 low", bus.TX_OUT, 1'b0);
    chk("abort bit3 busy", bus.busy, 1'b1);
    rst = 1'b0;
    #1;
    chk_idle("async abort");
    bus.data_valid = 1'b1;
    @(negedge clk);
    chk_idle("held in reset");
    rst = 1'b1;
    send(vecs[2], -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
